// File: rtl/opmux_pipe_if.sv
// Operand selector bus: select/source request side, result side and error status.
// Combinational bundle only, no latency of its own.
// Backpressure: sel_vld/sel_rdy on the request side, out_vld/out_rdy on the result side.
interface opmux_pipe_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 15
);
  logic                  sel_vld;
  logic                  sel_rdy;
  logic [NSRC-1:0]       sel_in;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic                  out_vld;
  logic                  out_rdy;
  logic [WIDTH-1:0]      alu_out;
  logic [WIDTH-1:0]      adr_out;
  logic                  sel_err;
  logic [7:0]            err_cnt;
  logic                  err_clr;

  // Producer/consumer side (operand fetch stage and its downstream user)
  modport master (
    output sel_vld, sel_in, src_bus, out_rdy, err_clr,
    input  sel_rdy, out_vld, alu_out, adr_out, sel_err, err_cnt
  );

  // Selector side
  modport slave (
    input  sel_vld, sel_in, src_bus, out_rdy, err_clr,
    output sel_rdy, out_vld, alu_out, adr_out, sel_err, err_cnt
  );
endinterface

// File: rtl/opmux_pipe.sv
// One-hot ALU/address operand selector with registered valid/ready output stage.
// Latency: one cycle from accept to out_vld; one word per cycle while out_rdy=1.
// Backpressure: one-entry skid buffer, sel_rdy is a register (no out_rdy->sel_rdy path).
module opmux_pipe #(
  parameter int              WIDTH      = 16,
  parameter int              NSRC       = 15,
  parameter logic [NSRC-1:0] ADDR_MASK  = {NSRC{1'b1}},
  parameter bit              ALLOW_ZERO = 1'b1
) (
  input  logic        clkc,
  input  logic        reset,
  opmux_pipe_if.slave io
);

  // EMPTY: nothing held; ONE: OUT slot full; TWO: OUT and SKID full
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sel_rdy;
  logic [WIDTH-1:0] r_out_alu;
  logic [WIDTH-1:0] r_out_adr;
  logic [WIDTH-1:0] r_skid_alu;
  logic [WIDTH-1:0] r_skid_adr;
  logic             r_sel_err;
  logic [7:0]       r_err_cnt;

  logic             w_accept;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_adr;
  logic [NSRC-1:0]  w_sel_m1;
  logic             w_multi;
  logic             w_any;
  logic             w_viol;
  logic             w_ld_out_new;
  logic             w_ld_out_skid;
  logic             w_ld_skid;

  assign w_accept = io.sel_vld & r_sel_rdy;

  // OR together every selected source; multi-hot selects merge without priority
  always_comb begin
    w_alu = '0;
    w_adr = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (io.sel_in[k]) begin
        w_alu = w_alu | io.src_bus[k*WIDTH +: WIDTH];
        if (ADDR_MASK[k]) begin
          w_adr = w_adr | io.src_bus[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set
  assign w_sel_m1 = io.sel_in - NSRC'(1);
  assign w_multi  = |(io.sel_in & w_sel_m1);
  assign w_any    = |io.sel_in;
  assign w_viol   = w_accept & (w_multi | (!ALLOW_ZERO & !w_any));

  // Slot occupancy next-state and which slot loads from where
  always_comb begin
    w_state_nxt   = r_state;
    w_ld_out_new  = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt  = ST_ONE;
          w_ld_out_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && io.out_rdy) begin
          w_ld_out_new = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_ld_skid   = 1'b1;
        end else if (io.out_rdy) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // sel_rdy is low here, so only the drain can happen
        if (io.out_rdy) begin
          w_state_nxt   = ST_ONE;
          w_ld_out_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State register; sel_rdy is precomputed from the next state so it stays a flop output
  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_sel_rdy <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_rdy <= (w_state_nxt != ST_TWO);
    end
  end

  // OUT and SKID data slots; OUT holds whenever it is not reloaded
  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      r_out_alu  <= '0;
      r_out_adr  <= '0;
      r_skid_alu <= '0;
      r_skid_adr <= '0;
    end else begin
      if (w_ld_out_new) begin
        r_out_alu <= w_alu;
        r_out_adr <= w_adr;
      end else if (w_ld_out_skid) begin
        r_out_alu <= r_skid_alu;
        r_out_adr <= r_skid_adr;
      end
      if (w_ld_skid) begin
        r_skid_alu <= w_alu;
        r_skid_adr <= w_adr;
      end
    end
  end

  // Sticky error flag and saturating count; a violation in the clear cycle still registers
  always_ff @(posedge clkc or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (io.err_clr) begin
      r_sel_err <= w_viol;
      r_err_cnt <= w_viol ? 8'd1 : 8'd0;
    end else if (w_viol) begin
      r_sel_err <= 1'b1;
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign io.sel_rdy = r_sel_rdy;
  assign io.out_vld = (r_state != ST_EMPTY);
  assign io.alu_out = r_out_alu;
  assign io.adr_out = r_out_adr;
  assign io.sel_err = r_sel_err;
  assign io.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_opmux_pipe.sv
// Bench for opmux_pipe: two instances (default mask/zero-legal, and mask 5037/zero-illegal)
// share one stimulus stream and are compared against a two-deep FIFO reference model.
module tb_opmux_pipe;
  localparam int W    = 16;
  localparam int N    = 15;
  localparam logic [N-1:0] MASK1 = 15'h5037;

  logic clkc;
  logic reset;
  logic             sel_vld;
  logic [N-1:0]     sel_in;
  logic [N*W-1:0]   src_bus;
  logic             out_rdy;
  logic             err_clr;

  opmux_pipe_if #(.WIDTH(W), .NSRC(N)) if0 ();
  opmux_pipe_if #(.WIDTH(W), .NSRC(N)) if1 ();

  assign if0.sel_vld = sel_vld;
  assign if0.sel_in  = sel_in;
  assign if0.src_bus = src_bus;
  assign if0.out_rdy = out_rdy;
  assign if0.err_clr = err_clr;
  assign if1.sel_vld = sel_vld;
  assign if1.sel_in  = sel_in;
  assign if1.src_bus = src_bus;
  assign if1.out_rdy = out_rdy;
  assign if1.err_clr = err_clr;

  opmux_pipe #(.WIDTH(W), .NSRC(N)) u_dut0 (
    .clkc(clkc), .reset(reset), .io(if0)
  );
  opmux_pipe #(.WIDTH(W), .NSRC(N), .ADDR_MASK(MASK1), .ALLOW_ZERO(1'b0)) u_dut1 (
    .clkc(clkc), .reset(reset), .io(if1)
  );

  initial clkc = 1'b0;
  always #5 clkc = ~clkc;

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] adr0;
    logic [W-1:0] adr1;
  } word_t;

  typedef struct {
    logic [N-1:0] sel;
    logic [W-1:0] s0, s1, s3;
    logic [W-1:0] alu, adr0, adr1;
    bit           v0, v1;
  } vec_t;

  int    n_vec = 0;
  int    n_bad = 0;
  word_t q[$];
  bit    e0, e1;
  int    c0, c1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_src(input int k, input logic [W-1:0] v);
    src_bus[k*W +: W] = v;
  endtask

  task automatic set_base();
    for (int k = 0; k < N; k++) set_src(k, 16'h1000 + 16'(k));
  endtask

  function automatic word_t mk(input logic [N-1:0] sel, input logic [N*W-1:0] bus);
    word_t w;
    logic [N-1:0] m;
    logic [W-1:0] s;
    m = MASK1;
    w.alu = '0; w.adr0 = '0; w.adr1 = '0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) begin
        s = bus[k*W +: W];
        w.alu  = w.alu | s;
        w.adr0 = w.adr0 | s;
        if (m[k]) w.adr1 = w.adr1 | s;
      end
    end
    return w;
  endfunction

  task automatic check_all();
    bit ev;
    ev = (q.size() > 0);
    chk("out_vld0", 16'(if0.out_vld), 16'(ev));
    chk("out_vld1", 16'(if1.out_vld), 16'(ev));
    chk("sel_rdy0", 16'(if0.sel_rdy), 16'(q.size() < 2));
    chk("sel_rdy1", 16'(if1.sel_rdy), 16'(q.size() < 2));
    if (ev) begin
      chk("alu0", if0.alu_out, q[0].alu);
      chk("adr0", if0.adr_out, q[0].adr0);
      chk("alu1", if1.alu_out, q[0].alu);
      chk("adr1", if1.adr_out, q[0].adr1);
    end
    chk("sel_err0", 16'(if0.sel_err), 16'(e0));
    chk("err_cnt0", 16'(if0.err_cnt), 16'(c0));
    chk("sel_err1", 16'(if1.sel_err), 16'(e1));
    chk("err_cnt1", 16'(if1.err_cnt), 16'(c1));
  endtask

  // Inputs are already driven (we sit at a negedge); advance one edge and check.
  task automatic cycle();
    bit acc, pop, v0, v1;
    int pc;
    word_t w;
    acc = sel_vld && (q.size() < 2);
    pop = out_rdy && (q.size() > 0);
    w   = mk(sel_in, src_bus);
    pc  = $countones(sel_in);
    v0  = acc && (pc >= 2);
    v1  = acc && (pc >= 2 || pc == 0);
    @(posedge clkc);
    if (pop) q.delete(0);
    if (acc) q.push_back(w);
    if (err_clr) begin
      e0 = v0; c0 = v0 ? 1 : 0;
      e1 = v1; c1 = v1 ? 1 : 0;
    end else begin
      if (v0) begin e0 = 1'b1; if (c0 < 255) c0++; end
      if (v1) begin e1 = 1'b1; if (c1 < 255) c1++; end
    end
    @(negedge clkc);
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    e0 = 1'b0; e1 = 1'b0; c0 = 0; c1 = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_vld0"}, 16'(if0.out_vld), 16'd0);
    chk({tag, "_vld1"}, 16'(if1.out_vld), 16'd0);
    chk({tag, "_rdy0"}, 16'(if0.sel_rdy), 16'd1);
    chk({tag, "_rdy1"}, 16'(if1.sel_rdy), 16'd1);
    chk({tag, "_alu0"}, if0.alu_out, 16'd0);
    chk({tag, "_adr1"}, if1.adr_out, 16'd0);
    chk({tag, "_err0"}, 16'(if0.sel_err), 16'd0);
    chk({tag, "_cnt1"}, 16'(if1.err_cnt), 16'd0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{15'h0008, 16'h1000, 16'h1001, 16'h1003, 16'h1003, 16'h1003, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{15'h0008, 16'h1000, 16'h1001, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{15'h0001, 16'h1000, 16'h1001, 16'h1003, 16'h1000, 16'h1000, 16'h1000, 1'b0, 1'b0};
    tbl[3] = '{15'h4000, 16'h1000, 16'h1001, 16'h1003, 16'h100E, 16'h100E, 16'h100E, 1'b0, 1'b0};
    tbl[4] = '{15'h0000, 16'h1000, 16'h1001, 16'h1003, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[5] = '{15'h0003, 16'h00F0, 16'h0F00, 16'h1003, 16'h0FF0, 16'h0FF0, 16'h0FF0, 1'b1, 1'b1};
    tbl[6] = '{15'h0018, 16'h1000, 16'h1001, 16'h1003, 16'h1007, 16'h1007, 16'h1004, 1'b1, 1'b1};
    tbl[7] = '{15'h0006, 16'h1000, 16'h1001, 16'h1003, 16'h1003, 16'h1003, 16'h1003, 1'b1, 1'b1};

    reset = 1'b1; sel_vld = 1'b0; sel_in = '0; src_bus = '0; out_rdy = 1'b0; err_clr = 1'b0;
    model_reset();
    @(negedge clkc);
    @(negedge clkc);
    chk_reset_vals("reset");
    reset = 1'b0;

    // Single-word vectors; err_clr rides along so each entry's error status stands alone
    for (int i = 0; i < 8; i++) begin
      set_base();
      set_src(0, tbl[i].s0); set_src(1, tbl[i].s1); set_src(3, tbl[i].s3);
      sel_in = tbl[i].sel; sel_vld = 1'b1; out_rdy = 1'b1; err_clr = 1'b1;
      cycle();
      chk($sformatf("tbl%0d_vld", i), 16'(if0.out_vld), 16'd1);
      chk($sformatf("tbl%0d_alu", i), if0.alu_out, tbl[i].alu);
      chk($sformatf("tbl%0d_adr0", i), if0.adr_out, tbl[i].adr0);
      chk($sformatf("tbl%0d_adr1", i), if1.adr_out, tbl[i].adr1);
      chk($sformatf("tbl%0d_err0", i), 16'(if0.sel_err), 16'(tbl[i].v0));
      chk($sformatf("tbl%0d_cnt0", i), 16'(if0.err_cnt), 16'(tbl[i].v0));
      chk($sformatf("tbl%0d_err1", i), 16'(if1.sel_err), 16'(tbl[i].v1));
      chk($sformatf("tbl%0d_cnt1", i), 16'(if1.err_cnt), 16'(tbl[i].v1));
    end
    err_clr = 1'b0;

    // Saturation: 300 more violations on top of the count of 1
    set_base(); sel_in = 15'h0003;
    repeat (300) cycle();
    chk("sat_cnt0", 16'(if0.err_cnt), 16'd255);
    chk("sat_cnt1", 16'(if1.err_cnt), 16'd255);
    chk("sat_err0", 16'(if0.sel_err), 16'd1);

    // Clear with nothing accepted
    sel_vld = 1'b0; err_clr = 1'b1;
    cycle();
    chk("clr_err0", 16'(if0.sel_err), 16'd0);
    chk("clr_cnt0", 16'(if0.err_cnt), 16'd0);
    chk("clr_cnt1", 16'(if1.err_cnt), 16'd0);
    err_clr = 1'b0;

    // A, B, C with out_rdy low for two edges after A; A's source changes after capture
    set_base(); sel_vld = 1'b1; sel_in = 15'h0001; out_rdy = 1'b0;
    cycle();
    chk("abc1_alu", if0.alu_out, 16'h1000);
    chk("abc1_rdy", 16'(if0.sel_rdy), 16'd1);
    set_src(0, 16'hDEAD); sel_in = 15'h0002;
    cycle();
    chk("abc2_alu", if0.alu_out, 16'h1000);
    chk("abc2_rdy", 16'(if0.sel_rdy), 16'd0);
    sel_in = 15'h0004;
    cycle();
    chk("abc3_alu", if0.alu_out, 16'h1000);
    chk("abc3_rdy", 16'(if0.sel_rdy), 16'd0);
    out_rdy = 1'b1;
    cycle();
    chk("abc4_alu", if0.alu_out, 16'h1001);
    chk("abc4_rdy", 16'(if0.sel_rdy), 16'd1);
    cycle();
    chk("abc5_alu", if0.alu_out, 16'h1002);
    chk("abc5_vld", 16'(if0.out_vld), 16'd1);
    sel_vld = 1'b0;
    cycle();
    chk("abc6_vld", 16'(if0.out_vld), 16'd0);

    // Reset while both slots are full and the error counters are non-zero
    set_base(); sel_vld = 1'b1; out_rdy = 1'b0; sel_in = 15'h0003;
    cycle();
    sel_in = 15'h0004;
    cycle();
    chk("two_rdy", 16'(if0.sel_rdy), 16'd0);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_two");
    model_reset();
    @(negedge clkc);
    reset = 1'b0;
    set_base(); sel_vld = 1'b1; sel_in = 15'h0010; out_rdy = 1'b1;
    cycle();
    chk("post_alu", if0.alu_out, 16'h1004);
    chk("post_adr1", if1.adr_out, 16'h1004);
    chk("post_err0", 16'(if0.sel_err), 16'd0);

    // Random traffic against the FIFO model
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0, 3:    sel_in = 15'(1) << $urandom_range(0, N - 1);
        1:       sel_in = '0;
        default: sel_in = 15'($urandom());
      endcase
      for (int k = 0; k < N; k++) set_src(k, 16'($urandom()));
      sel_vld = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/opmux_pipe.md
# opmux_pipe

Parametrised, registered successor to the core's one-hot ALU/address operand selector. It takes a one-hot source select plus a packed bus of NSRC operand sources and produces an ALU operand and an address-path operand. The address operand is the subset of sources enabled by ADDR_MASK. Results are delivered through a valid/ready pipeline stage with a one-entry skid buffer, so the operand fetch stage can be retimed without combinational ready paths. Select-vector violations are flagged and counted.

## Interface
- WIDTH, 16: operand width in bits.
- NSRC, 15: number of sources; select width.
- ADDR_MASK, {NSRC{1'b1}}: bit k=1 lets source k drive adr_out.
- ALLOW_ZERO, 1: 1 means an all-zero select is legal (operand 0); 0 means all-zero is a violation.

- clkc  in  1  core clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel_vld  in  1  select/source word valid.
- sel_rdy  out  1  block can accept; driven from a register.
- sel_in  in  NSRC  one-hot source select.
- src_bus  in  NSRC*WIDTH  source k at bits [k*WIDTH +: WIDTH].
- out_vld  out  1  output word valid.
- out_rdy  in  1  consumer accepts output.
- alu_out  out  WIDTH  OR of all selected sources.
- adr_out  out  WIDTH  OR of selected sources with ADDR_MASK bit set.
- sel_err  out  1  sticky select-violation flag.
- err_cnt  out  8  saturating violation count.
- err_clr  in  1  synchronous clear of sel_err and err_cnt.

## Operation
- Accept: sel_vld & sel_rdy at a rising edge. sel_in and src_bus are sampled at that edge only. Later source changes do not affect the captured word.
- Computed word:
  - alu_out = OR over k of (sel_in[k] ? src_k : 0).
  - adr_out = the same OR, restricted to k with ADDR_MASK[k]=1.
  - A multi-hot select ORs its sources; no priority is applied.
- Storage is two slots: OUT (drives the outputs) and SKID.
- Slot states: EMPTY (out_vld=0), ONE (OUT full, SKID empty), TWO (both full).
  - EMPTY + accept → ONE. The word goes to OUT.
  - ONE + accept + out_rdy → ONE. The new word replaces OUT.
  - ONE + accept + !out_rdy → TWO. The word goes to SKID.
  - ONE + no accept + out_rdy → EMPTY.
  - TWO + out_rdy → ONE. SKID moves to OUT. No accept is possible because sel_rdy=0.
  - TWO + !out_rdy → TWO. Both slots hold.
- sel_rdy = !(next state == TWO), registered. It is 0 exactly while in TWO.
- Violation: an accepted sel_in with popcount ≥ 2, or popcount = 0 when ALLOW_ZERO=0. The violating word is still delivered as computed.
- On a violation: sel_err ← 1, and err_cnt ← err_cnt+1, saturating at 255.
- err_clr: sel_err ← 0 and err_cnt ← 0. If a violation is accepted in the same cycle, the result is sel_err=1, err_cnt=1, so the new event is not lost.

## Timing
- Reset values (asynchronous, held while reset=1): out_vld=0, sel_rdy=1, alu_out=0, adr_out=0, sel_err=0, err_cnt=0, SKID empty.
- Reset during a transfer discards both slots. No output handshake completes while reset is high.
- Latency: accept at edge N gives out_vld=1 with the word after edge N.
- Throughput: 1 word/cycle while out_rdy=1.
- Output stability: while out_vld=1 and out_rdy=0, alu_out and adr_out are held stable.
- Order: words leave in acceptance order. No word is dropped or duplicated.
- Transfer out: out_vld & out_rdy at an edge.
- Combinational paths: none from out_rdy to sel_rdy, and none from the inputs to the outputs.
- err_cnt and sel_err update at the accepting edge.

## Test plan
- Reset, then WIDTH=16, NSRC=15, src_k=16'h1000+k, sel_in=15'h0008, out_rdy=1 → the cycle after accept shows out_vld=1, alu_out=16'h1003, adr_out=16'h1003 (ADDR_MASK all ones), sel_err=0.
- ADDR_MASK=15'h5037, sel_in=15'h0008 with src_3=16'hBEEF → alu_out=16'hBEEF, adr_out=16'h0000.
- Back-to-back words A,B,C with out_rdy low for 2 cycles after A is accepted → B is held in SKID, sel_rdy=0 and C is stalled. After out_rdy rises, the outputs are A, B, C in order with no gaps once flowing.
- sel_in=15'h0003 with src_0=16'h00F0 and src_1=16'h0F00 → alu_out=16'h0FF0, sel_err=1, err_cnt=1. Then 300 further violations → err_cnt saturates at 255.
- err_clr=1 together with an accepted violation → sel_err=1, err_cnt=1. err_clr alone → sel_err=0, err_cnt=0.
- Assert reset while in TWO → immediately out_vld=0, sel_rdy=1 and all outputs 0. After release, the first accepted word appears unaffected by the pre-reset data.
